// File: rtl/period_meter_pkg.sv
// Shared definitions for the period meter: FSM encoding and the nominal
// 1 kHz tick period that the clock divider is built around.
package period_meter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_MEASURE = 2'd2
    } state_e;

    // The divider toggles every DIV_HALF_TERM+1 cycles, giving this full period.
    localparam int NOMINAL_KHZ_PERIOD = 100000;
    localparam int DIV_HALF_TERM      = NOMINAL_KHZ_PERIOD / 2 - 1;

endpackage

// File: rtl/period_meter_sync_edge_detect.sv
// Two-flop synchronizer plus one edge flop for an asynchronous input.
// Reusable for buttons and other slow async lines.
module sync_edge_detect (
    input  logic clk_i,
    input  logic resetn,
    input  logic async_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic s1_q;
    logic s2_q;
    logic s3_q;

    always_ff @(posedge clk_i or negedge resetn) begin
        if (!resetn) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= async_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign level_o = s2_q;
    assign rise_o  = s2_q & ~s3_q;
    assign fall_o  = ~s2_q & s3_q;

endmodule

// File: rtl/period_meter.sv
// Measures period and high time of a slow signal in clk_i cycles, with
// timeout detection when rising edges stop arriving.
module period_meter
    import period_meter_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int TIMEOUT_CYC = 200000
) (
    input  logic             clk_i,
    input  logic             resetn,
    input  logic             en_i,
    input  logic             sig_i,
    output logic [CNT_W-1:0] period_o,
    output logic [CNT_W-1:0] high_o,
    output logic             valid_o,
    output logic             timeout_o,
    output logic             busy_o
);

    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYC);

    logic             level;
    logic             rise;
    logic             fall;
    logic [CNT_W-1:0] cnt_p_q, cnt_p_d;
    logic [CNT_W-1:0] cnt_h_q, cnt_h_d;
    logic [CNT_W-1:0] hold_q;
    logic [CNT_W-1:0] period_q;
    logic [CNT_W-1:0] high_q;
    logic             fall_seen_q;
    logic             valid_q;
    logic             timeout_q;
    state_e           state_q, state_d;
    logic             take_meas;
    logic             take_timeout;
    logic             latch_fall;

    sync_edge_detect u_sync (
        .clk_i   (clk_i),
        .resetn  (resetn),
        .async_i (sig_i),
        .level_o (level),
        .rise_o  (rise),
        .fall_o  (fall)
    );

    // Counters free-run in every state; the rise that arms a measurement restarts them.
    always_comb begin
        cnt_p_d = cnt_p_q;
        cnt_h_d = cnt_h_q;
        if (rise) begin
            cnt_p_d = CNT_ONE;
            cnt_h_d = CNT_ONE;
        end else begin
            if (cnt_p_q != CNT_MAX) begin
                cnt_p_d = cnt_p_q + CNT_ONE;
            end
            if (level && (cnt_h_q != CNT_MAX)) begin
                cnt_h_d = cnt_h_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk_i or negedge resetn) begin
        if (!resetn) begin
            cnt_p_q <= '0;
            cnt_h_q <= '0;
        end else begin
            cnt_p_q <= cnt_p_d;
            cnt_h_q <= cnt_h_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        take_meas    = 1'b0;
        take_timeout = 1'b0;
        latch_fall   = 1'b0;
        if (!en_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_ARM;
                ST_ARM: begin
                    if (rise) begin
                        state_d = ST_MEASURE;
                    end
                end
                ST_MEASURE: begin
                    latch_fall = fall;
                    // A rise in the same cycle as the timeout threshold still counts.
                    if (rise) begin
                        take_meas = 1'b1;
                    end else if (cnt_p_q == TIMEOUT_VAL) begin
                        take_timeout = 1'b1;
                        state_d      = ST_ARM;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // High time is staged at the fall and only published with its period, so
    // period_o/high_o always describe the same cycle of sig_i.
    always_ff @(posedge clk_i or negedge resetn) begin
        if (!resetn) begin
            hold_q      <= '0;
            fall_seen_q <= 1'b0;
            period_q    <= '0;
            high_q      <= '0;
            valid_q     <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            valid_q <= take_meas;
            if (rise) begin
                fall_seen_q <= 1'b0;
            end else if (latch_fall) begin
                hold_q      <= cnt_h_q;
                fall_seen_q <= 1'b1;
            end
            if (take_meas) begin
                period_q  <= cnt_p_q;
                high_q    <= fall_seen_q ? hold_q : cnt_h_q;
                timeout_q <= 1'b0;
            end else if (take_timeout) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign period_o  = period_q;
    assign high_o    = high_q;
    assign valid_o   = valid_q;
    assign timeout_o = timeout_q;
    assign busy_o    = (state_q == ST_MEASURE);

endmodule

// File: tb/tb_period_meter.sv
// Scoreboard bench for period_meter: stimulus pushes expected period/high
// pairs, a monitor pops them whenever valid_o pulses.
module tb_period_meter;

    typedef struct packed {
        logic [31:0] period;
        logic [31:0] high;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        resetn;
    logic        en_i;
    logic        sig_i;
    logic [31:0] period_o;
    logic [31:0] high_o;
    logic        valid_o;
    logic        timeout_o;
    logic        busy_o;

    exp_t expQ[$];
    exp_t mon;
    int   total = 0;
    int   bad = 0;
    bit   haveRef = 1'b0;
    int   lastLen = 0;
    int   lastHi = 0;

    period_meter #(
        .CNT_W       (32),
        .TIMEOUT_CYC (50)
    ) dut (
        .clk_i     (clk_i),
        .resetn    (resetn),
        .en_i      (en_i),
        .sig_i     (sig_i),
        .period_o  (period_o),
        .high_o    (high_o),
        .valid_o   (valid_o),
        .timeout_o (timeout_o),
        .busy_o    (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    // Each period starts with a rise; that rise closes the previous period,
    // so its expected result is queued at that moment.
    task automatic applyStimulus(input int hi, input int lo, input int n, input bit track);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            if (track && haveRef) begin
                e.period = 32'(lastLen);
                e.high   = 32'(lastHi);
                expQ.push_back(e);
            end
            sig_i = 1'b1;
            waitCycles(hi);
            sig_i = 1'b0;
            waitCycles(lo);
            if (track) begin
                lastLen = hi + lo;
                lastHi  = hi;
                haveRef = 1'b1;
            end
        end
    endtask

    always @(negedge clk_i) begin
        if (resetn === 1'b1 && valid_o === 1'b1) begin
            if (expQ.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_valid: got period=%0d high=%0d, expected no valid",
                         period_o, high_o);
            end else begin
                mon = expQ.pop_front();
                checkOutput("period", period_o, mon.period);
                checkOutput("high", high_o, mon.high);
                checkOutput("timeout_at_valid", {31'b0, timeout_o}, 32'd0);
            end
        end
    end

    initial begin
        resetn = 1'b0;
        en_i   = 1'b0;
        sig_i  = 1'b0;
        waitCycles(3);
        checkOutput("reset_period", period_o, 32'd0);
        checkOutput("reset_high", high_o, 32'd0);
        checkOutput("reset_valid", {31'b0, valid_o}, 32'd0);
        checkOutput("reset_timeout", {31'b0, timeout_o}, 32'd0);
        checkOutput("reset_busy", {31'b0, busy_o}, 32'd0);
        #2 resetn = 1'b1;
        waitCycles(2);
        en_i = 1'b1;

        applyStimulus(5, 5, 4, 1'b1);
        applyStimulus(20, 20, 3, 1'b1);
        applyStimulus(3, 7, 3, 1'b1);

        // Hold low: the last rise reaches the counters 3 cycles after sig_i,
        // so the threshold is hit 53 cycles after that rise was driven.
        waitCycles(37);
        checkOutput("timeout_before", {31'b0, timeout_o}, 32'd0);
        waitCycles(10);
        checkOutput("timeout_after", {31'b0, timeout_o}, 32'd1);
        checkOutput("busy_in_arm", {31'b0, busy_o}, 32'd0);
        checkOutput("period_hold_timeout", period_o, 32'd10);
        checkOutput("high_hold_timeout", high_o, 32'd3);
        haveRef = 1'b0;

        applyStimulus(5, 5, 3, 1'b1);
        checkOutput("timeout_cleared", {31'b0, timeout_o}, 32'd0);

        checkOutput("busy_measuring", {31'b0, busy_o}, 32'd1);
        en_i = 1'b0;
        waitCycles(1);
        checkOutput("busy_after_disable", {31'b0, busy_o}, 32'd0);
        applyStimulus(5, 5, 3, 1'b0);
        haveRef = 1'b0;
        checkOutput("period_hold_disable", period_o, 32'd10);
        checkOutput("high_hold_disable", high_o, 32'd5);
        en_i = 1'b1;
        waitCycles(3);
        checkOutput("busy_rearmed", {31'b0, busy_o}, 32'd0);
        applyStimulus(4, 6, 3, 1'b1);

        waitCycles(2);
        checkOutput("busy_before_reset", {31'b0, busy_o}, 32'd1);
        @(posedge clk_i);
        #3 resetn = 1'b0;
        #1;
        checkOutput("midreset_period", period_o, 32'd0);
        checkOutput("midreset_high", high_o, 32'd0);
        checkOutput("midreset_valid", {31'b0, valid_o}, 32'd0);
        checkOutput("midreset_timeout", {31'b0, timeout_o}, 32'd0);
        checkOutput("midreset_busy", {31'b0, busy_o}, 32'd0);
        waitCycles(2);
        haveRef = 1'b0;
        resetn  = 1'b1;
        waitCycles(2);
        applyStimulus(5, 5, 3, 1'b1);

        waitCycles(20);
        checkOutput("queue_empty", 32'(expQ.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
